csa_accumulator: RTL and testbench



---
 rtl/csa_accumulator.sv | 128 ++++++++++++
 tb/tb_csa_accumulator.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/csa_accumulator.sv
// Streaming unsigned multi-operand accumulator: carry-save absorb, chunked ripple resolve, valid/ready result.
// Optional macro CSA_ACC_SAT_EN saturates out_data to all-ones on overflow.
module csa_accumulator #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ACCW  = 24,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACCW-1:0]  out_data,
  output logic             out_ovf
);

  localparam int unsigned NCHUNK = ACCW / CHUNK;
  localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {ACCUM, RESOLVE, HOLD} state_t;

  state_t            state, state_next;
  logic [ACCW-1:0]   s, c, result;
  logic [ACCW-1:0]   s_next, c_next, result_next, out_data_next;
  logic              ovf, ovf_next, cin, cin_next;
  logic              in_ready_next, out_valid_next, out_ovf_next;
  logic [KW-1:0]     k, k_next;
  logic [ACCW-1:0]   x, maj;
  logic [CHUNK:0]    csum;
  logic [ACCW+CHUNK-1:0] rshift;

  // Next-state, datapath and output decode.
  always_comb begin
    state_next    = state;
    s_next        = s;
    c_next        = c;
    ovf_next      = ovf;
    result_next   = result;
    cin_next      = cin;
    k_next        = k;
    out_data_next = out_data;
    out_ovf_next  = out_ovf;

    x      = ACCW'(in_data);
    maj    = (s & c) | (s & x) | (c & x);
    csum   = (CHUNK+1)'(s[CHUNK-1:0]) + (CHUNK+1)'(c[CHUNK-1:0]) + (CHUNK+1)'(cin);
    // Resolved chunk enters at the top; after NCHUNK cycles the LSB chunk has reached bit 0.
    rshift = {csum[CHUNK-1:0], result} >> CHUNK;

    case (state)
      ACCUM: begin
        if (in_valid && in_ready) begin
          s_next   = s ^ c ^ x;
          c_next   = {maj[ACCW-2:0], 1'b0};
          ovf_next = ovf | maj[ACCW-1];
          if (in_last) begin
            state_next = RESOLVE;
            k_next     = '0;
            cin_next   = 1'b0;
          end
        end
      end
      RESOLVE: begin
        result_next = rshift[ACCW-1:0];
        s_next      = s >> CHUNK;
        c_next      = c >> CHUNK;
        cin_next    = csum[CHUNK];
        k_next      = k + KW'(1);
        if (k == KW'(NCHUNK - 1)) begin
          ovf_next     = ovf | csum[CHUNK];
          out_ovf_next = ovf | csum[CHUNK];
`ifdef CSA_ACC_SAT_EN
          out_data_next = (ovf | csum[CHUNK]) ? '1 : rshift[ACCW-1:0];
`else
          out_data_next = rshift[ACCW-1:0];
`endif
          k_next       = '0;
          state_next   = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          s_next     = '0;
          c_next     = '0;
          ovf_next   = 1'b0;
          state_next = ACCUM;
        end
      end
      default: state_next = ACCUM;
    endcase

    in_ready_next  = (state_next == ACCUM);
    out_valid_next = (state_next == HOLD);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ACCUM;
      s         <= '0;
      c         <= '0;
      ovf       <= 1'b0;
      result    <= '0;
      cin       <= 1'b0;
      k         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      state     <= state_next;
      s         <= s_next;
      c         <= c_next;
      ovf       <= ovf_next;
      result    <= result_next;
      cin       <= cin_next;
      k         <= k_next;
      in_ready  <= in_ready_next;
      out_valid <= out_valid_next;
      out_data  <= out_data_next;
      out_ovf   <= out_ovf_next;
    end
  end

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed self-checking bench for csa_accumulator at default parameters.
module tb_csa_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic        out_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  csa_accumulator dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [15:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_n(input logic [15:0] d, input int n);
    for (int i = 0; i < n; i++) send_beat(d, (i == n - 1));
  endtask

  // Called right after the edge that accepted the last beat.
  task automatic get_result(input string tag, input logic [23:0] exp_data, input logic exp_ovf);
    int cycles = 0;
    out_ready = 1'b1;
    while (!out_valid && cycles < 20) begin
      tick();
      cycles++;
    end
    check({tag, "_latency"}, 32'(cycles), 32'd3);
    check({tag, "_data"}, 32'(out_data), 32'(exp_data));
    check({tag, "_ovf"}, 32'(out_ovf), 32'(exp_ovf));
    tick();
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);

    send_beat(16'h0003, 1'b0);
    send_beat(16'h0005, 1'b1);
    get_result("two_beat", 24'h000008, 1'b0);

    send_beat(16'hFFFF, 1'b1);
    get_result("single", 24'h00FFFF, 1'b0);

    send_n(16'hFFFF, 257);
`ifdef CSA_ACC_SAT_EN
    get_result("ovf257", 24'hFFFFFF, 1'b1);
`else
    get_result("ovf257", 24'h00FEFF, 1'b1);
`endif

    send_n(16'hFFFF, 256);
    get_result("no_ovf256", 24'hFFFF00, 1'b0);

    // Backpressure: result must hold and stray input beats must be ignored.
    out_ready = 1'b0;
    send_beat(16'h0008, 1'b0);
    send_beat(16'h0008, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    check("bp_valid_rise", 32'(out_valid), 32'd1);
    in_valid = 1'b1;
    in_data  = 16'h0055;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", 32'(out_data), 32'h10);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_hs_valid", 32'(out_valid), 32'd0);
    check("bp_hs_in_ready", 32'(in_ready), 32'd1);
    send_beat(16'h0001, 1'b0);
    send_beat(16'h0001, 1'b1);
    get_result("after_bp", 24'h000002, 1'b0);

    // Reset while resolving discards the packet.
    out_ready = 1'b1;
    send_beat(16'h0009, 1'b1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    check("mid_rst_no_stale", 32'(out_valid), 32'd0);
    send_beat(16'h0007, 1'b1);
    get_result("after_rst", 24'h000007, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
